// File: rtl/mc_seq_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
package mc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_B,
        CLS_JAL
    } cls_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_ENTRY  = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;

endpackage

// File: rtl/mc_seq_decode.sv
// Combinational opcode classifier; anything outside the supported subset is illegal.
module mc_seq_decode
    import mc_seq_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_R:    cls = CLS_R;
            OP_I:    cls = CLS_I;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_B:    cls = CLS_B;
            OP_JAL:  cls = CLS_JAL;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_seq.sv
// Multi-cycle control sequencer: per-state datapath enables, req/ready memory
// handshakes, and retired-instruction / cycle counters.
module mc_seq
    import mc_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    state_t state, state_nx;
    cls_t   cls_q, cls_dec;
    logic   illegal;
    logic   retire;

    mc_seq_decode u_decode (
        .opcode  (opcode),
        .cls     (cls_dec),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cls_q   <= CLS_NONE;
            instret <= '0;
            cycles  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_DECODE) cls_q <= cls_dec;
            if (retire) instret <= instret + CNT_W'(1);
            if (state != ST_IDLE && state != ST_HALT) cycles <= cycles + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        halted    = 1'b0;
        retire    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gating with rst_n keeps every output low while reset is held.
                if (start && rst_n) begin
                    pc_we    = 1'b1;
                    pc_sel   = PC_ENTRY;
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
                if (imem_ready) state_nx = ST_DECODE;
            end
            ST_DECODE: state_nx = illegal ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (cls_q)
                    CLS_R: begin
                        alu_op   = ALU_RTYPE;
                        state_nx = ST_WB;
                    end
                    CLS_I: begin
                        alu_src  = 1'b1;
                        state_nx = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_src  = 1'b1;
                        state_nx = ST_MEM;
                    end
                    CLS_B: begin
                        alu_op   = ALU_BRANCH;
                        pc_we    = 1'b1;
                        pc_sel   = zero ? PC_BRANCH : PC_PLUS4;
                        retire   = 1'b1;
                        state_nx = ST_FETCH;
                    end
                    CLS_JAL: begin
                        reg_we   = 1'b1;
                        wb_sel   = WB_PC4;
                        pc_we    = 1'b1;
                        pc_sel   = PC_JUMP;
                        retire   = 1'b1;
                        state_nx = ST_FETCH;
                    end
                    default: state_nx = ST_HALT;
                endcase
            end
            ST_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (cls_q == CLS_LW);
                mem_write = (cls_q == CLS_SW);
                if (dmem_ready) begin
                    if (cls_q == CLS_LW) begin
                        state_nx = ST_WB;
                    end else begin
                        // Store retires on the completing cycle so the PC moves exactly once.
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_we   = 1'b1;
                wb_sel   = (cls_q == CLS_LW) ? WB_MEM : WB_ALU;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
